// File: rtl/daq_event_builder_if.sv
// Channel-result input bus and event-stream output bus of the DAQ event builder.
// The builder sits on the slave side; the DSP pipeline and the event consumer sit on the master side.
interface daq_event_builder_if #(
    parameter int unsigned N_CH = 2,
    parameter int unsigned N_P  = 12,
    parameter int unsigned N_A  = 20,
    parameter int unsigned N_T  = 32
);
    logic [N_T-1:0]            time_ms;
    logic [N_CH-1:0][N_P-1:0]  a_peak;
    logic [N_CH-1:0][N_A-1:0]  a_area;
    logic [N_CH-1:0]           peak_ready;
    logic [N_CH-1:0]           area_ready;
    logic                      out_ready;
    logic                      out_valid;
    logic [N_T-1:0]            time_event;
    logic [N_CH-1:0][N_P-1:0]  a_peak_event;
    logic [N_CH-1:0][N_A-1:0]  a_area_event;
    logic [N_CH-1:0]           hit_pattern;

    modport master (
        output time_ms, a_peak, a_area, peak_ready, area_ready, out_ready,
        input  out_valid, time_event, a_peak_event, a_area_event, hit_pattern
    );

    modport slave (
        input  time_ms, a_peak, a_area, peak_ready, area_ready, out_ready,
        output out_valid, time_event, a_peak_event, a_area_event, hit_pattern
    );
endinterface

// File: rtl/daq_event_builder.sv
// Coincidence-window event builder: latches per-channel peak/area, applies OR/AND/majority
// trigger, timestamps accepted events and queues them in a first-word-fall-through FIFO.
module daq_event_builder #(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned N_P        = 12,
    parameter int unsigned N_A        = 20,
    parameter int unsigned N_T        = 32,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned N_WIN      = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    daq_event_builder_if.slave           io_bus,
    input  logic [N_CH-1:0]              i_ch_mask,
    input  logic [1:0]                   i_mode,
    input  logic [$clog2(N_CH+1)-1:0]    i_min_mult,
    input  logic [N_WIN-1:0]             i_window,
    output logic [DEPTH_LOG2:0]          o_fifo_level,
    output logic [15:0]                  o_dropped_count,
    output logic                         o_busy
);
    localparam int unsigned MW    = $clog2(N_CH + 1);
    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StCollect, StEval} state_e;

    state_e                   r_state;
    logic [N_T-1:0]           r_time;
    logic [N_CH-1:0]          r_mask;
    logic [1:0]               r_mode;
    logic [MW-1:0]            r_min_mult;
    logic [N_WIN-1:0]         r_win;
    logic [N_WIN-1:0]         r_cnt;
    logic [N_CH-1:0]          r_pk_v;
    logic [N_CH-1:0]          r_ar_v;
    logic [N_CH-1:0][N_P-1:0] r_pk;
    logic [N_CH-1:0][N_A-1:0] r_ar;
    logic [15:0]              r_dropped;

    logic [DEPTH_LOG2-1:0]    r_wr_ptr;
    logic [DEPTH_LOG2-1:0]    r_rd_ptr;
    logic [LW-1:0]            r_level;
    logic [N_T-1:0]           r_mem_time [DEPTH];
    logic [N_CH-1:0][N_P-1:0] r_mem_pk   [DEPTH];
    logic [N_CH-1:0][N_A-1:0] r_mem_ar   [DEPTH];
    logic [N_CH-1:0]          r_mem_hit  [DEPTH];

    logic [N_CH-1:0]          w_mask;
    logic [N_CH-1:0]          w_pk_stb;
    logic [N_CH-1:0]          w_ar_stb;
    logic [N_CH-1:0]          w_pk_v_nx;
    logic [N_CH-1:0]          w_ar_v_nx;
    logic                     w_all_hit;
    logic                     w_open;
    logic [N_WIN-1:0]         w_win_eff;
    logic [N_CH-1:0]          w_hit;
    logic [MW-1:0]            w_mult;
    logic [MW-1:0]            w_thr;
    logic                     w_trig;
    logic [N_CH-1:0][N_P-1:0] w_evt_pk;
    logic [N_CH-1:0][N_A-1:0] w_evt_ar;
    logic                     w_full;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;

    always_comb begin
        // Strobes are qualified by the live mask when opening and by the latched mask afterwards.
        w_mask    = (r_state == StIdle) ? i_ch_mask : r_mask;
        w_pk_stb  = (r_state == StEval) ? '0 : (io_bus.peak_ready & w_mask & ~r_pk_v);
        w_ar_stb  = (r_state == StEval) ? '0 : (io_bus.area_ready & w_mask & ~r_ar_v);
        w_pk_v_nx = r_pk_v | w_pk_stb;
        w_ar_v_nx = r_ar_v | w_ar_stb;
        w_all_hit = ((w_pk_v_nx & w_ar_v_nx) == w_mask);
        w_open    = (r_state == StIdle) && ((w_pk_stb | w_ar_stb) != '0);
        w_win_eff = (i_window == '0) ? N_WIN'(1) : i_window;

        w_hit  = r_pk_v & r_ar_v;
        w_mult = '0;
        for (int i = 0; i < N_CH; i++) begin
            w_mult = w_mult + MW'(w_hit[i]);
            w_evt_pk[i] = w_hit[i] ? r_pk[i] : '0;
            w_evt_ar[i] = w_hit[i] ? r_ar[i] : '0;
        end
        w_thr = (r_min_mult == '0) ? MW'(1) : r_min_mult;
        case (r_mode)
            2'd1:    w_trig = (w_hit == r_mask);
            2'd2:    w_trig = (w_mult >= w_thr);
            default: w_trig = (w_hit != '0);
        endcase

        w_full = (r_level == LW'(DEPTH));
        w_pop  = (r_level != '0) && io_bus.out_ready;
        // A same-cycle pop frees the slot a full FIFO needs.
        w_push = (r_state == StEval) && w_trig && (!w_full || w_pop);
        w_drop = (r_state == StEval) && w_trig && !w_push;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_time     <= '0;
            r_mask     <= '0;
            r_mode     <= '0;
            r_min_mult <= '0;
            r_win      <= '0;
            r_cnt      <= '0;
            r_pk_v     <= '0;
            r_ar_v     <= '0;
            r_pk       <= '0;
            r_ar       <= '0;
            r_dropped  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_open) begin
                        r_time     <= io_bus.time_ms;
                        r_mask     <= i_ch_mask;
                        r_mode     <= i_mode;
                        r_min_mult <= i_min_mult;
                        r_win      <= w_win_eff;
                        r_cnt      <= N_WIN'(1);
                        r_state    <= (w_all_hit || w_win_eff == N_WIN'(1)) ? StEval : StCollect;
                    end
                end
                StCollect: begin
                    r_cnt <= r_cnt + N_WIN'(1);
                    if (w_all_hit || r_cnt == r_win - N_WIN'(1)) r_state <= StEval;
                end
                default: r_state <= StIdle;
            endcase

            if (r_state == StEval) begin
                r_pk_v <= '0;
                r_ar_v <= '0;
            end else begin
                r_pk_v <= w_pk_v_nx;
                r_ar_v <= w_ar_v_nx;
            end
            for (int i = 0; i < N_CH; i++) begin
                if (w_pk_stb[i]) r_pk[i] <= io_bus.a_peak[i];
                if (w_ar_stb[i]) r_ar[i] <= io_bus.a_area[i];
            end

            if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            if (w_push && !w_pop)      r_level <= r_level + LW'(1);
            else if (w_pop && !w_push) r_level <= r_level - LW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_time[r_wr_ptr] <= r_time;
            r_mem_pk[r_wr_ptr]   <= w_evt_pk;
            r_mem_ar[r_wr_ptr]   <= w_evt_ar;
            r_mem_hit[r_wr_ptr]  <= w_hit;
        end
    end

    always_comb begin
        io_bus.out_valid    = (r_level != '0);
        io_bus.time_event   = io_bus.out_valid ? r_mem_time[r_rd_ptr] : '0;
        io_bus.a_peak_event = io_bus.out_valid ? r_mem_pk[r_rd_ptr] : '0;
        io_bus.a_area_event = io_bus.out_valid ? r_mem_ar[r_rd_ptr] : '0;
        io_bus.hit_pattern  = io_bus.out_valid ? r_mem_hit[r_rd_ptr] : '0;
        o_fifo_level        = r_level;
        o_dropped_count     = r_dropped;
        o_busy              = (r_state != StIdle);
    end
endmodule

// File: tb/tb_daq_event_builder.sv
// Directed bench for daq_event_builder: a 2-channel/4-deep instance and a 4-channel/16-deep
// instance share clock and reset; each task drives one scenario and checks hand-computed values.
module tb_daq_event_builder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] tms = 32'd1000;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tms <= tms + 32'd1;

    daq_event_builder_if #(.N_CH(2), .N_P(12), .N_A(20), .N_T(32)) if2 ();
    daq_event_builder_if #(.N_CH(4), .N_P(12), .N_A(20), .N_T(32)) if4 ();
    assign if2.time_ms = tms;
    assign if4.time_ms = tms;

    logic [1:0]  mask2, mode2, mm2;
    logic [15:0] win2, drop2;
    logic [2:0]  lvl2;
    logic        busy2;
    logic [3:0]  mask4;
    logic [1:0]  mode4;
    logic [2:0]  mm4;
    logic [15:0] win4, drop4;
    logic [4:0]  lvl4;
    logic        busy4;

    daq_event_builder #(.N_CH(2), .N_P(12), .N_A(20), .N_T(32), .DEPTH_LOG2(2), .N_WIN(16)) u_d2 (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(if2), .i_ch_mask(mask2), .i_mode(mode2),
        .i_min_mult(mm2), .i_window(win2), .o_fifo_level(lvl2), .o_dropped_count(drop2),
        .o_busy(busy2)
    );

    daq_event_builder #(.N_CH(4), .N_P(12), .N_A(20), .N_T(32), .DEPTH_LOG2(4), .N_WIN(16)) u_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(if4), .i_ch_mask(mask4), .i_mode(mode4),
        .i_min_mult(mm4), .i_window(win4), .o_fifo_level(lvl4), .o_dropped_count(drop4),
        .o_busy(busy4)
    );

    logic [31:0] ts_q [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Both strobes on one channel for one cycle; returns one cycle later.
    task automatic full2(input int ch, input logic [11:0] pk, input logic [19:0] ar);
        if2.peak_ready[ch] = 1'b1;
        if2.area_ready[ch] = 1'b1;
        if2.a_peak[ch]     = pk;
        if2.a_area[ch]     = ar;
        tick();
        if2.peak_ready = '0;
        if2.area_ready = '0;
    endtask

    task automatic drive4(input logic [3:0] chs);
        for (int i = 0; i < 4; i++) begin
            if (chs[i]) begin
                if4.peak_ready[i] = 1'b1;
                if4.area_ready[i] = 1'b1;
                if4.a_peak[i]     = 12'(10 * (i + 1));
                if4.a_area[i]     = 20'(100 * (i + 1));
            end
        end
        tick();
        if4.peak_ready = '0;
        if4.area_ready = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        if2.peak_ready = '0; if2.area_ready = '0; if2.a_peak = '0; if2.a_area = '0;
        if2.out_ready = 1'b0;
        if4.peak_ready = '0; if4.area_ready = '0; if4.a_peak = '0; if4.a_area = '0;
        if4.out_ready = 1'b0;
        mask2 = '0; mode2 = '0; mm2 = '0; win2 = '0;
        mask4 = '0; mode4 = '0; mm4 = '0; win4 = '0;
        ticks(2);
        rst_n = 1'b1;
        tick();
        total++; if (lvl2 !== 3'd0) begin bad++; $display("FAIL rst_level2: got %0d want 0", lvl2); end
        total++; if (drop2 !== 16'd0) begin bad++; $display("FAIL rst_drop2: got %0d want 0", drop2); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL rst_busy2: got %0b want 0", busy2); end
        total++; if (if2.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid2: got %0b want 0", if2.out_valid); end
        total++; if (if2.time_event !== 32'd0) begin bad++; $display("FAIL rst_time2: got %0d want 0", if2.time_event); end
        total++; if (lvl4 !== 5'd0 || busy4 !== 1'b0) begin bad++; $display("FAIL rst_d4: got level %0d busy %0b want 0 0", lvl4, busy4); end
    endtask

    task automatic test_or_window();
        logic [31:0] ts;
        mask2 = 2'b11; mode2 = 2'd0; win2 = 16'd10;
        ts = tms;
        full2(0, 12'd1000, 20'd5000);
        ticks(2);
        // Repeat peak on ch0 at t0+3 must lose to the first one.
        if2.peak_ready[0] = 1'b1; if2.a_peak[0] = 12'd7;
        tick();
        if2.peak_ready = '0;
        ticks(5);
        total++; if (busy2 !== 1'b1 || if2.out_valid !== 1'b0) begin bad++; $display("FAIL or_t9: got busy %0b valid %0b want 1 0", busy2, if2.out_valid); end
        tick();
        total++; if (busy2 !== 1'b1 || if2.out_valid !== 1'b0) begin bad++; $display("FAIL or_eval_t10: got busy %0b valid %0b want 1 0", busy2, if2.out_valid); end
        tick();
        total++; if (busy2 !== 1'b0 || if2.out_valid !== 1'b1) begin bad++; $display("FAIL or_t11: got busy %0b valid %0b want 0 1", busy2, if2.out_valid); end
        total++; if (if2.hit_pattern !== 2'b01) begin bad++; $display("FAIL or_hit: got %b want 01", if2.hit_pattern); end
        total++; if (if2.a_peak_event[0] !== 12'd1000) begin bad++; $display("FAIL or_peak0: got %0d want 1000", if2.a_peak_event[0]); end
        total++; if (if2.a_area_event[0] !== 20'd5000) begin bad++; $display("FAIL or_area0: got %0d want 5000", if2.a_area_event[0]); end
        total++; if (if2.a_peak_event[1] !== 12'd0 || if2.a_area_event[1] !== 20'd0) begin bad++; $display("FAIL or_ch1_zero: got %0d %0d want 0 0", if2.a_peak_event[1], if2.a_area_event[1]); end
        total++; if (if2.time_event !== ts) begin bad++; $display("FAIL or_time: got %0d want %0d", if2.time_event, ts); end
        total++; if (lvl2 !== 3'd1) begin bad++; $display("FAIL or_level: got %0d want 1", lvl2); end
        if2.out_ready = 1'b1;
        tick();
        if2.out_ready = 1'b0;
        total++; if (if2.out_valid !== 1'b0 || lvl2 !== 3'd0) begin bad++; $display("FAIL or_pop: got valid %0b level %0d want 0 0", if2.out_valid, lvl2); end
    endtask

    task automatic test_and_early();
        logic [31:0] ts;
        mode2 = 2'd1; win2 = 16'd10;
        ts = tms;
        full2(0, 12'd11, 20'd22);
        ticks(3);
        full2(1, 12'hFFB, 20'd33);
        total++; if (busy2 !== 1'b1 || if2.out_valid !== 1'b0) begin bad++; $display("FAIL and_eval_t5: got busy %0b valid %0b want 1 0", busy2, if2.out_valid); end
        tick();
        total++; if (busy2 !== 1'b0 || if2.out_valid !== 1'b1) begin bad++; $display("FAIL and_t6: got busy %0b valid %0b want 0 1", busy2, if2.out_valid); end
        total++; if (if2.hit_pattern !== 2'b11) begin bad++; $display("FAIL and_hit: got %b want 11", if2.hit_pattern); end
        total++; if (if2.a_peak_event[1] !== 12'hFFB || if2.a_area_event[1] !== 20'd33) begin bad++; $display("FAIL and_ch1: got %h %0d want ffb 33", if2.a_peak_event[1], if2.a_area_event[1]); end
        total++; if (if2.time_event !== ts) begin bad++; $display("FAIL and_time: got %0d want %0d", if2.time_event, ts); end
        if2.out_ready = 1'b1;
        tick();
        if2.out_ready = 1'b0;
        full2(0, 12'd11, 20'd22);
        ticks(10);
        total++; if (busy2 !== 1'b0 || if2.out_valid !== 1'b0) begin bad++; $display("FAIL and_late_t11: got busy %0b valid %0b want 0 0", busy2, if2.out_valid); end
        tick();
        full2(1, 12'd5, 20'd6);
        ticks(11);
        total++; if (if2.out_valid !== 1'b0 || drop2 !== 16'd0 || busy2 !== 1'b0) begin bad++; $display("FAIL and_late: got valid %0b drop %0d busy %0b want 0 0 0", if2.out_valid, drop2, busy2); end
    endtask

    task automatic test_overflow();
        mode2 = 2'd0; mask2 = 2'b11; win2 = 16'd0;
        for (int k = 0; k < 6; k++) begin
            ts_q[k] = tms;
            full2(0, 12'(100 + k), 20'(200 + k));
            tick();
        end
        total++; if (lvl2 !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d want 4", lvl2); end
        total++; if (drop2 !== 16'd2) begin bad++; $display("FAIL ovf_dropped: got %0d want 2", drop2); end
        total++; if (if2.a_peak_event[0] !== 12'd100 || if2.time_event !== ts_q[0]) begin bad++; $display("FAIL ovf_head: got %0d @%0d want 100 @%0d", if2.a_peak_event[0], if2.time_event, ts_q[0]); end
    endtask

    task automatic test_full_pop_eval();
        ts_q[6] = tms;
        full2(0, 12'd106, 20'd206);
        if2.out_ready = 1'b1;
        tick();
        if2.out_ready = 1'b0;
        total++; if (lvl2 !== 3'd4) begin bad++; $display("FAIL fpe_level: got %0d want 4", lvl2); end
        total++; if (drop2 !== 16'd2) begin bad++; $display("FAIL fpe_dropped: got %0d want 2", drop2); end
        total++; if (if2.a_peak_event[0] !== 12'd101) begin bad++; $display("FAIL fpe_head: got %0d want 101", if2.a_peak_event[0]); end
    endtask

    task automatic test_drain();
        int          order [4] = '{1, 2, 3, 6};
        logic [31:0] prev;
        logic [11:0] exp_pk;
        prev = '0;
        if2.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp_pk = 12'(100 + order[j]);
            total++; if (if2.out_valid !== 1'b1 || if2.a_peak_event[0] !== exp_pk) begin bad++; $display("FAIL drain_peak%0d: got valid %0b peak %0d want 1 %0d", j, if2.out_valid, if2.a_peak_event[0], exp_pk); end
            total++; if (if2.time_event !== ts_q[order[j]] || !(if2.time_event > prev)) begin bad++; $display("FAIL drain_time%0d: got %0d want %0d (prev %0d)", j, if2.time_event, ts_q[order[j]], prev); end
            prev = ts_q[order[j]];
            tick();
        end
        ticks(2);
        if2.out_ready = 1'b0;
        total++; if (if2.out_valid !== 1'b0 || lvl2 !== 3'd0) begin bad++; $display("FAIL drain_empty: got valid %0b level %0d want 0 0", if2.out_valid, lvl2); end
    endtask

    task automatic test_reset_mid();
        win2 = 16'd0;
        for (int k = 0; k < 2; k++) begin
            full2(1, 12'd9, 20'd9);
            tick();
        end
        win2 = 16'd10;
        full2(0, 12'd1, 20'd1);
        ticks(2);
        total++; if (busy2 !== 1'b1 || lvl2 !== 3'd2) begin bad++; $display("FAIL rmid_pre: got busy %0b level %0d want 1 2", busy2, lvl2); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (if2.out_valid !== 1'b0 || lvl2 !== 3'd0 || busy2 !== 1'b0) begin bad++; $display("FAIL rmid_async: got valid %0b level %0d busy %0b want 0 0 0", if2.out_valid, lvl2, busy2); end
        total++; if (drop2 !== 16'd0) begin bad++; $display("FAIL rmid_drop: got %0d want 0", drop2); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_majority();
        logic [31:0] ts;
        mask4 = 4'b1111; mode4 = 2'd2; mm4 = 3'd3; win4 = 16'd8;
        ts = tms;
        drive4(4'b0111);
        ticks(7);
        total++; if (busy4 !== 1'b1 || if4.out_valid !== 1'b0) begin bad++; $display("FAIL maj_eval_t8: got busy %0b valid %0b want 1 0", busy4, if4.out_valid); end
        tick();
        total++; if (if4.out_valid !== 1'b1 || if4.hit_pattern !== 4'b0111) begin bad++; $display("FAIL maj3_hit: got valid %0b hit %b want 1 0111", if4.out_valid, if4.hit_pattern); end
        total++; if (if4.a_peak_event[2] !== 12'd30 || if4.a_area_event[3] !== 20'd0) begin bad++; $display("FAIL maj3_data: got %0d %0d want 30 0", if4.a_peak_event[2], if4.a_area_event[3]); end
        total++; if (if4.time_event !== ts || lvl4 !== 5'd1) begin bad++; $display("FAIL maj3_time: got %0d level %0d want %0d 1", if4.time_event, lvl4, ts); end
        drive4(4'b0011);
        mm4 = 3'd1;  // changed after open: the latched threshold of 3 still applies
        ticks(9);
        total++; if (lvl4 !== 5'd1 || drop4 !== 16'd0 || busy4 !== 1'b0) begin bad++; $display("FAIL maj2_nopush: got level %0d drop %0d busy %0b want 1 0 0", lvl4, drop4, busy4); end
        mm4 = 3'd0;
        drive4(4'b0100);
        ticks(9);
        total++; if (lvl4 !== 5'd2) begin bad++; $display("FAIL maj_min0: got level %0d want 2", lvl4); end
        mask4 = 4'b0000;
        drive4(4'b1111);
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL mask0_busy: got %0b want 0", busy4); end
        ticks(10);
        total++; if (lvl4 !== 5'd2 || busy4 !== 1'b0) begin bad++; $display("FAIL mask0_level: got level %0d busy %0b want 2 0", lvl4, busy4); end
    endtask

    initial begin
        test_reset();
        test_or_window();
        test_and_early();
        test_overflow();
        test_full_pop_eval();
        test_drain();
        test_reset_mid();
        test_majority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
